y_mem_stage: RTL and testbench

//  Memory/writeback stage downstream of the execute stage. Accepts one EX result
//  per transaction via valid/ready. Loads/stores go to data memory over a
//  req/ack handshake. Then presents a single-cycle writeback to the register file.

---
 rtl/y_mem_stage_if.sv | 44 ++++
 rtl/y_mem_stage.sv | 149 ++++++++++++++
 tb/tb_y_mem_stage.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/y_mem_stage_if.sv
// Bundle for y_mem_stage: EX-side accept handshake, data-memory req/ack and the
// writeback strobe. "master" is the environment side, "slave" is the stage itself.
interface y_mem_stage_if #(
  parameter int WIDTH = 32
);
  // ex_valid/ex_ready: a transfer happens on a rising edge where both are 1;
  // ex_valid may be raised without waiting for ex_ready. dm_req stays high with
  // stable dm_we/dm_addr/dm_wdata until the edge that samples dm_ack=1.
  // wb_valid is a one-cycle strobe with no back-pressure.
  logic             ex_valid;
  logic             ex_ready;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] rd2;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic [4:0]       rd;
  logic             dm_req;
  logic             dm_we;
  logic [WIDTH-1:0] dm_addr;
  logic [WIDTH-1:0] dm_wdata;
  logic             dm_ack;
  logic [WIDTH-1:0] dm_rdata;
  logic             wb_valid;
  logic             wb_en;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             err;

  modport master (
    output ex_valid, z, rd2, mem_read, mem_write, mem_to_reg, reg_write, rd,
    output dm_ack, dm_rdata,
    input  ex_ready, dm_req, dm_we, dm_addr, dm_wdata,
    input  wb_valid, wb_en, wb_rd, wb_data, err
  );

  modport slave (
    input  ex_valid, z, rd2, mem_read, mem_write, mem_to_reg, reg_write, rd,
    input  dm_ack, dm_rdata,
    output ex_ready, dm_req, dm_we, dm_addr, dm_wdata,
    output wb_valid, wb_en, wb_rd, wb_data, err
  );
endinterface

// File: rtl/y_mem_stage.sv
// Multicycle memory/writeback stage: IDLE -> (ACCESS) -> WB, one transaction at a time.
// Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module y_mem_stage #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  y_mem_stage_if.slave bus,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WB     = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_z;
  logic             r_mem_read;
  logic             r_mem_write;
  logic             r_mem_to_reg;
  logic             r_reg_write;
  logic [4:0]       r_rd;
  logic             r_dm_req;
  logic             r_dm_we;
  logic [WIDTH-1:0] r_dm_addr;
  logic [WIDTH-1:0] r_dm_wdata;
  logic             r_wb_valid;
  logic             r_wb_en;
  logic [4:0]       r_wb_rd;
  logic [WIDTH-1:0] r_wb_data;
  logic             w_is_mem;
  logic             w_load_wb;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_timeout;
  // Fires on the last allowed ACCESS cycle; an ack in that same cycle still wins.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1)) && !bus.dm_ack;
  assign bus.err   = r_err;
`else
  assign bus.err   = 1'b0;
`endif

  assign w_is_mem  = bus.mem_read | bus.mem_write;
  // Read+write together executes as a store, so it never writes back load data.
  assign w_load_wb = r_mem_to_reg & r_mem_read & ~r_mem_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_z          <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_dm_req     <= 1'b0;
      r_dm_we      <= 1'b0;
      r_dm_addr    <= '0;
      r_dm_wdata   <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_en      <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
`ifdef MEM_TIMEOUT_EN
      r_cnt        <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ex_valid) begin
            r_z          <= bus.z;
            r_mem_read   <= bus.mem_read;
            r_mem_write  <= bus.mem_write;
            r_mem_to_reg <= bus.mem_to_reg;
            r_reg_write  <= bus.reg_write;
            r_rd         <= bus.rd;
            if (w_is_mem) begin
              r_state    <= S_ACCESS;
              r_dm_req   <= 1'b1;
              r_dm_we    <= bus.mem_write;
              r_dm_addr  <= {bus.z[WIDTH-1:2], 2'b00};
              r_dm_wdata <= bus.rd2;
`ifdef MEM_TIMEOUT_EN
              r_cnt      <= '0;
`endif
            end else begin
              r_state    <= S_WB;
              r_wb_valid <= 1'b1;
              r_wb_en    <= bus.reg_write & (bus.rd != 5'd0);
              r_wb_rd    <= bus.rd;
              r_wb_data  <= bus.z;
            end
          end
        end
        S_ACCESS: begin
          if (bus.dm_ack) begin
            r_state    <= S_WB;
            r_dm_req   <= 1'b0;
            r_wb_valid <= 1'b1;
            r_wb_en    <= r_reg_write & (r_rd != 5'd0);
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_load_wb ? bus.dm_rdata : r_z;
          end
`ifdef MEM_TIMEOUT_EN
          else if (w_timeout) begin
            r_state    <= S_WB;
            r_dm_req   <= 1'b0;
            r_wb_valid <= 1'b1;
            r_wb_en    <= 1'b0;
            r_wb_rd    <= r_rd;
            r_wb_data  <= '0;
            r_err      <= 1'b1;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
          end
`endif
        end
        S_WB: begin
          r_state    <= S_IDLE;
          r_wb_valid <= 1'b0;
          r_wb_en    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          r_err      <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ex_ready = (r_state == S_IDLE) && !reset;
  assign bus.dm_req   = r_dm_req;
  assign bus.dm_we    = r_dm_we;
  assign bus.dm_addr  = r_dm_addr;
  assign bus.dm_wdata = r_dm_wdata;
  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_en    = r_wb_en;
  assign bus.wb_rd    = r_wb_rd;
  assign bus.wb_data  = r_wb_data;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_y_mem_stage.sv
// Randomized scoreboard bench for y_mem_stage: driver, memory responder, writeback monitor.
// Define MEM_TIMEOUT_EN to also exercise the access-timeout abort.
module tb_y_mem_stage;
  localparam int W     = 32;
  localparam int TO    = 15;
  localparam int NOACK = -1;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  dbg_state;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  y_mem_stage_if #(.WIDTH(W)) bus ();

  y_mem_stage #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];       // expected wb_data
  logic [6:0]   exp_meta_q[$];  // {err, wb_en, wb_rd}
  int unsigned  exp_cyc_q[$];   // cycle in which wb_valid is due
  logic [W:0]   mem_req_q[$];   // {dm_we, dm_addr}
  logic [W-1:0] mem_wdata_q[$];
  int           mem_delay_q[$];
  logic [W-1:0] mem_rdata_q[$];
  bit           hold_off = 1'b0;
  bit           force_spur = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic [W-1:0] z, input logic [W-1:0] rd2,
                       input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic [4:0] rdi, input int delay, input logic [W-1:0] rdata,
                       input bit push);
    int          waited;
    int unsigned acc;
    @(negedge clk);
    bus.ex_valid   = 1'b1;
    bus.z          = z;
    bus.rd2        = rd2;
    bus.mem_read   = mr;
    bus.mem_write  = mw;
    bus.mem_to_reg = m2r;
    bus.reg_write  = rw;
    bus.rd         = rdi;
    waited = 0;
    while (!bus.ex_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.ex_ready) begin
      chk("accept_wait", 0, 1);
      bus.ex_valid = 1'b0;
      return;
    end
    acc = cyc + 1;  // cycle number right after the accepting edge
    if (push) begin
      if (delay == NOACK) begin
        exp_q.push_back('0);
        exp_meta_q.push_back({1'b1, 1'b0, rdi});
        exp_cyc_q.push_back(acc + TO);
      end else begin
        exp_q.push_back((m2r && mr && !mw) ? rdata : z);
        exp_meta_q.push_back({1'b0, rw && (rdi != 5'd0), rdi});
        exp_cyc_q.push_back((mr || mw) ? acc + 1 + delay : acc);
      end
      if (mr || mw) begin
        mem_req_q.push_back({mw, z & ~32'h3});
        mem_wdata_q.push_back(rd2);
        mem_delay_q.push_back(delay);
        mem_rdata_q.push_back(rdata);
      end
    end
    @(negedge clk);
    bus.ex_valid   = 1'b0;
    bus.z          = $urandom;
    bus.rd2        = $urandom;
    bus.mem_read   = 1'($urandom_range(0, 1));
    bus.mem_write  = 1'($urandom_range(0, 1));
    bus.mem_to_reg = 1'($urandom_range(0, 1));
    bus.reg_write  = 1'($urandom_range(0, 1));
    bus.rd         = 5'($urandom_range(0, 31));
  endtask

  // ---------------- memory responder ----------------
  bit           busy = 1'b0;
  int           cur_delay;
  int           cnt;
  logic [W:0]   cur_req;
  logic [W-1:0] cur_wdata;
  logic [W-1:0] cur_rdata;

  initial begin
    bus.dm_ack   = 1'b0;
    bus.dm_rdata = '0;
    forever begin
      @(negedge clk);
      bus.dm_ack = 1'b0;
      if (reset) begin
        busy = 1'b0;
      end else begin
        if (!busy && bus.dm_req && !hold_off) begin
          if (mem_req_q.size() == 0) begin
            chk("unexpected_dm_req", bus.dm_req, 0);
          end else begin
            cur_req   = mem_req_q.pop_front();
            cur_wdata = mem_wdata_q.pop_front();
            cur_delay = mem_delay_q.pop_front();
            cur_rdata = mem_rdata_q.pop_front();
            chk("dm_we", bus.dm_we, cur_req[W]);
            chk("dm_addr", bus.dm_addr, cur_req[W-1:0]);
            chk("dm_wdata", bus.dm_wdata, cur_wdata);
            busy = 1'b1;
            cnt  = 0;
          end
        end
        if (busy) begin
          if (!bus.dm_req) begin
            if (cur_delay != NOACK) chk("dm_req_held", bus.dm_req, 1);
            busy = 1'b0;
          end else begin
            if (cnt > 0) chk("dm_addr_stable", bus.dm_addr, cur_req[W-1:0]);
            if (cur_delay != NOACK && cnt == cur_delay) begin
              bus.dm_ack   = 1'b1;
              bus.dm_rdata = cur_rdata;
              busy = 1'b0;
            end else begin
              cnt++;
            end
          end
        end else if (!bus.dm_req && (force_spur || $urandom_range(0, 7) == 0)) begin
          bus.dm_ack   = 1'b1;  // stray ack outside ACCESS
          bus.dm_rdata = $urandom;
        end
      end
    end
  end

  // ---------------- writeback monitor ----------------
  bit           prev_wb = 1'b0;
  logic [W-1:0] m_data;
  logic [6:0]   m_meta;
  int unsigned  m_cyc;

  initial begin
    forever begin
      @(negedge clk);
      if (prev_wb) chk("wb_valid_one_cycle", bus.wb_valid, 0);
      if (!reset && bus.wb_valid) begin
        chk("ex_ready_in_wb", bus.ex_ready, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_wb_valid", bus.wb_valid, 0);
        end else begin
          m_data = exp_q.pop_front();
          m_meta = exp_meta_q.pop_front();
          m_cyc  = exp_cyc_q.pop_front();
          chk("wb_data", bus.wb_data, m_data);
          chk("wb_en", bus.wb_en, m_meta[5]);
          chk("err", bus.err, m_meta[6]);
          if (!m_meta[6]) chk("wb_rd", bus.wb_rd, m_meta[4:0]);
          chk("wb_cycle", cyc, m_cyc);
        end
      end
      prev_wb = bus.wb_valid;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int          waited;
    int          kind;
    logic        mr, mw;
    logic [4:0]  rdi;
    reset          = 1'b1;
    bus.ex_valid   = 1'b0;
    bus.z          = '0;
    bus.rd2        = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.rd         = '0;
    repeat (3) @(negedge clk);
    chk("rst_ex_ready", bus.ex_ready, 0);
    chk("rst_dm_req", bus.dm_req, 0);
    chk("rst_dm_we", bus.dm_we, 0);
    chk("rst_dm_addr", bus.dm_addr, 0);
    chk("rst_dm_wdata", bus.dm_wdata, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_en", bus.wb_en, 0);
    chk("rst_wb_rd", bus.wb_rd, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_state_idle", dbg_state, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ex_ready_after_rst", bus.ex_ready, 1);

    // directed cases
    issue(32'h0000_0011, 32'h0, 0, 0, 0, 1, 5'd5, 0, 32'h0, 1);
    issue(32'h0000_0104, 32'h1234_5678, 1, 0, 1, 1, 5'd7, 3, 32'hDEAD_BEEF, 1);
    issue(32'h0000_0203, 32'hA5A5_A5A5, 0, 1, 0, 0, 5'd9, 1, 32'h0BAD_F00D, 1);
    issue(32'h0000_0055, 32'h0, 0, 0, 0, 1, 5'd0, 0, 32'h0, 1);
    issue(32'h0000_0307, 32'h7777_0000, 1, 1, 1, 1, 5'd3, 0, 32'hFFFF_FFFF, 1);
    issue(32'hFFFF_FFFE, 32'h0, 1, 0, 1, 1, 5'd31, 0, 32'hC001_D00D, 1);

    // stray acks while idle must not move the stage
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    force_spur = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("spur_ex_ready", bus.ex_ready, 1);
      chk("spur_dm_req", bus.dm_req, 0);
    end
    force_spur = 1'b0;

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 3);
      mr   = (kind == 1) || (kind == 3);
      mw   = (kind == 2) || (kind == 3);
      rdi  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue($urandom, $urandom, mr, mw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rdi, $urandom_range(0, 4), $urandom, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef MEM_TIMEOUT_EN
    issue(32'h0000_0300, 32'h0, 1, 0, 1, 1, 5'd4, NOACK, 32'h0, 1);
`endif

    waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_pending", exp_q.size(), 0);

    // reset in the middle of an access abandons it
    hold_off = 1'b1;
    issue(32'h0000_0400, 32'h0, 1, 0, 1, 1, 5'd6, 0, 32'h0, 0);
    repeat (2) @(negedge clk);
    chk("req_before_reset", bus.dm_req, 1);
    reset = 1'b1;
    #1;
    chk("midrst_dm_req", bus.dm_req, 0);
    chk("midrst_wb_valid", bus.wb_valid, 0);
    chk("midrst_ex_ready", bus.ex_ready, 0);
    @(negedge clk);
    reset    = 1'b0;
    hold_off = 1'b0;
    @(negedge clk);
    chk("ready_after_midrst", bus.ex_ready, 1);
    repeat (5) @(negedge clk);
    chk("no_req_after_midrst", bus.dm_req, 0);
    issue(32'h0000_0021, 32'h0, 0, 0, 0, 1, 5'd2, 0, 32'h0, 1);
    repeat (4) @(negedge clk);
    chk("final_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
